// File: rtl/pe_acc.sv
// pe_acc: accumulates a configured number of signed PE products into one
// saturated dot-product result, handed to writeback on a valid/ready handshake.
module pe_acc #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_vld,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              acc_clr,
  input  logic              c1_vld,
  input  logic [PROD_W-1:0] c1_data,
  output logic              acc_busy,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              err_drop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The wide sum carries one guard bit; the top two bits disagree on overflow.
  function automatic logic sum_ovf(input logic signed [ACC_W:0] s);
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  // Clamp the guarded sum into the signed ACC_W range, direction from the guard bit.
  function automatic logic signed [ACC_W-1:0] sat_sum(input logic signed [ACC_W:0] s);
    logic signed [ACC_W-1:0] r;
    if (!sum_ovf(s))
      r = s[ACC_W-1:0];
    else if (s[ACC_W])
      r = {1'b1, {(ACC_W-1){1'b0}}};
    else
      r = {1'b0, {(ACC_W-1){1'b1}}};
    return r;
  endfunction

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         len_q, len_d;
  logic                     ovf_q, ovf_d;
  logic                     busy_q, busy_d;
  logic                     res_vld_q, res_vld_d;
  logic signed [ACC_W-1:0]  res_data_q, res_data_d;
  logic                     res_ovf_q, res_ovf_d;
  logic                     err_drop_q, err_drop_d;

  logic signed [ACC_W:0]    sum_w;
  logic signed [ACC_W-1:0]  sum_sat;
  logic                     ovf_next;

  // Guarded sum of the running total and the sign-extended product, then clamped.
  always_comb begin
    sum_w    = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-PROD_W){c1_data[PROD_W-1]}}, c1_data};
    sum_sat  = sat_sum(sum_w);
    ovf_next = ovf_q | sum_ovf(sum_w);
  end

  // Next-state and datapath update; abort overrides every other request.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    res_vld_d  = res_vld_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    err_drop_d = err_drop_q;

    if (c1_vld && state_q != S_ACC)
      err_drop_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_vld && cfg_len != '0) begin
          len_d   = cfg_len;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (c1_vld) begin
          acc_d = sum_sat;
          ovf_d = ovf_next;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == len_q - CNT_ONE) begin
            res_data_d = sum_sat;
            res_ovf_d  = ovf_next;
            res_vld_d  = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (res_rdy) begin
          res_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (acc_clr) begin
      state_d    = S_IDLE;
      acc_d      = '0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      res_vld_d  = 1'b0;
      res_ovf_d  = 1'b0;
      err_drop_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      err_drop_q <= err_drop_d;
    end
  end

  assign acc_busy = busy_q;
  assign res_vld  = res_vld_q;
  assign res_data = res_data_q;
  assign res_ovf  = res_ovf_q;
  assign err_drop = err_drop_q;

endmodule
